// File: rtl/max7219_if_arbiter.sv
// Round-robin arbiter sharing one max7219_if serializer between several frame producers.
// A grant is held for a whole cascade frame, which ends with the word sent with en_load=1.
module max7219_if_arbiter #(
  parameter int G_NB_REQ     = 2,
  parameter int G_DATA_WIDTH = 16,
  parameter int G_TIMEOUT    = 1024
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [G_NB_REQ-1:0]              i_req,
  input  logic [G_NB_REQ-1:0]              i_start,
  input  logic [G_NB_REQ-1:0]              i_en_load,
  input  logic [G_NB_REQ*G_DATA_WIDTH-1:0] i_data,
  output logic [G_NB_REQ-1:0]              o_gnt,
  output logic [G_NB_REQ-1:0]              o_done,
  output logic                             o_max7219_if_start,
  output logic                             o_max7219_if_en_load,
  output logic [G_DATA_WIDTH-1:0]          o_max7219_if_data,
  input  logic                             i_max7219_if_done,
  output logic                             o_busy
);

  localparam int PTR_W = (G_NB_REQ > 1) ? $clog2(G_NB_REQ) : 1;
  localparam int TMO_W = (G_TIMEOUT > 1) ? $clog2(G_TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_OWNED, S_BUSY} state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        owner_q, owner_d;
  logic [PTR_W-1:0]        rr_q, rr_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic [G_NB_REQ-1:0]     gnt_q, gnt_d;
  logic [G_NB_REQ-1:0]     done_q, done_d;
  logic                    start_q, start_d;
  logic                    en_load_q, en_load_d;
  logic [G_DATA_WIDTH-1:0] data_q, data_d;

  logic [G_DATA_WIDTH-1:0] req_data [G_NB_REQ];
  logic                    pick_found;
  logic [PTR_W-1:0]        pick_idx;
  logic [PTR_W-1:0]        cand;
  logic                    tmo_hit;
  logic                    rel;

  for (genvar gi = 0; gi < G_NB_REQ; gi++) begin : g_unpack
    assign req_data[gi] = i_data[gi*G_DATA_WIDTH +: G_DATA_WIDTH];
  end

  // First requester at or after the rr pointer, wrapping modulo G_NB_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < G_NB_REQ; i++) begin
      cand = PTR_W'((int'(rr_q) + i) % G_NB_REQ);
      if (!pick_found && i_req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign tmo_hit = (G_TIMEOUT != 0) && (int'(tmo_q) == G_TIMEOUT - 1);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    tmo_d     = tmo_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    start_d   = 1'b0;
    en_load_d = en_load_q;
    data_d    = data_q;
    rel       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d = S_OWNED;
          owner_d = pick_idx;
          gnt_d   = G_NB_REQ'(1) << pick_idx;
          tmo_d   = '0;
        end
      end
      S_OWNED: begin
        if (!i_req[owner_q]) begin
          rel = 1'b1;
        end else if (i_start[owner_q]) begin
          data_d    = req_data[owner_q];
          en_load_d = i_en_load[owner_q];
          start_d   = 1'b1;
          state_d   = S_BUSY;
        end else if (tmo_hit) begin
          rel = 1'b1;
        end else if (G_TIMEOUT != 0) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_BUSY: begin
        // A dropped request cannot abort a word in flight; it only ends the frame at done.
        if (i_max7219_if_done) begin
          done_d = G_NB_REQ'(1) << owner_q;
          if (en_load_q || !i_req[owner_q]) begin
            rel = 1'b1;
          end else begin
            state_d = S_OWNED;
            tmo_d   = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (rel) begin
      state_d = S_IDLE;
      gnt_d   = '0;
      tmo_d   = '0;
      rr_d    = (int'(owner_q) == G_NB_REQ - 1) ? '0 : owner_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      owner_q   <= '0;
      rr_q      <= '0;
      tmo_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      start_q   <= 1'b0;
      en_load_q <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      tmo_q     <= tmo_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      start_q   <= start_d;
      en_load_q <= en_load_d;
      data_q    <= data_d;
    end
  end

  assign o_gnt                = gnt_q;
  assign o_done               = done_q;
  assign o_max7219_if_start   = start_q;
  assign o_max7219_if_en_load = en_load_q;
  assign o_max7219_if_data    = data_q;
  assign o_busy               = (state_q != S_IDLE);

endmodule
